pipe_perf_monitor: RTL and testbench
====================================

PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_EVT, default 4, number of pipeline event channels (e.g. stall, flush, jump, branch).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-003 SHALL have parameter MAX_CYCLES, default 70, cycle limit after which the monitor halts; 0 = no limit.
REQ-004 SHALL have parameter SEL_W, default 3, readout select width; 2^SEL_W >= NUM_EVT+1.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  rising-edge clock.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 start_i  input  1  level; high moves IDLE to RUN.
REQ-009 clear_i  input  1  one-cycle pulse; zero counters, return to IDLE.
REQ-010 evt_i  input  NUM_EVT  per-channel event strobes, one count per high cycle.
REQ-011 snap_i  input  1  one-cycle pulse; copy live counters to shadow bank.
REQ-012 rd_sel_i  input  SEL_W  shadow select; 0 = cycle count, k = event k-1.
REQ-013 rd_data_o  output  CNT_W  registered shadow readout.
REQ-014 running_o  output  1  high in RUN.
REQ-015 halt_o  output  1  high in HALTED.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-017 IDLE->RUN on a rising edge with start_i=1; RUN->HALTED on the edge where cycle_cnt advances to MAX_CYCLES (MAX_CYCLES != 0); HALTED->IDLE only on clear_i or rst_i.
REQ-018 start_i SHALL be ignored in RUN and HALTED.
REQ-019 In RUN, cycle_cnt SHALL increment by 1 each edge; evt_cnt[k] SHALL increment by 1 each edge with evt_i[k]=1.
REQ-020 The final RUN cycle (transition to HALTED) SHALL still be counted, so halted cycle_cnt equals MAX_CYCLES exactly.
REQ-021 Counters SHALL hold in IDLE and HALTED.
REQ-022 Every counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-023 snap_i SHALL load the shadow bank with live values present before that edge's increment, in any state.
REQ-024 clear_i SHALL zero all live counters and enter IDLE; shadow bank is unaffected.
REQ-025 snap_i and clear_i together: shadow SHALL capture pre-clear values, live counters SHALL zero.
REQ-026 Priority: rst_i > clear_i > counting.
REQ-027 rd_data_o SHALL equal shadow[rd_sel_i] one cycle after rd_sel_i is presented; rd_sel_i > NUM_EVT SHALL read 0.
REQ-028 A snap and a read of the same entry in the same cycle SHALL return the old shadow value; the new value appears one cycle later.
REQ-029 running_o and halt_o SHALL be decoded from the registered state, glitch-free.

Reset
REQ-030 rst_i SHALL set state IDLE, all live and shadow counters 0, rd_data_o 0, running_o 0, halt_o 0.
REQ-031 rst_i asserted mid-RUN SHALL discard all counts on that edge; the events of that cycle SHALL NOT be counted.

Structure
REQ-032 State encoding and readout index constants (SEL_CYCLE = 0, event base = 1) SHALL live in shared package perf_pkg.
REQ-033 One sub-module, sat_counter (CNT_W-wide saturating counter with clear and enable), SHALL be instantiated NUM_EVT+1 times.

Verification
REQ-034 Reset, start_i=1, MAX_CYCLES=70, evt_i[0] high 12 cycles -> halt_o rises after 70 RUN edges; snap, sel 0 reads 70, sel 1 reads 12.
REQ-035 CNT_W=4, evt_i[1] high 20 RUN cycles -> snap, sel 2 reads 15 (saturated).
REQ-036 snap_i and clear_i in the same cycle with cycle_cnt=33 -> next-cycle read of sel 0 is 33; live counters 0; state IDLE.
REQ-037 rst_i pulsed at RUN cycle 10 with evt_i all high -> all outputs 0; after restart and a snap, sel 0..4 all read 0 before counting resumes.
REQ-038 MAX_CYCLES=0, 200 RUN cycles -> halt_o never asserts; sel 0 reads 200.
REQ-039 rd_sel_i=7 with NUM_EVT=4 -> rd_data_o = 0 one cycle later.

Source files
------------

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants for the pipeline performance monitor
//
// Purpose: FSM state encoding and shadow readout index constants shared by
//          pipe_perf_monitor and its testbench.
// Ports:   none (package).
package perf_pkg;

  // Each non-idle state owns one flop bit, so running_o and halt_o can be
  // taken straight from a register with no decode logic behind them.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // Readout / live bank layout: entry 0 is the cycle count, event k sits at
  // SEL_EVT_BASE + k.
  localparam int SEL_CYCLE    = 0;
  localparam int SEL_EVT_BASE = 1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating up-counter with clear and enable
//
// Purpose: counts enabled cycles and sticks at all-ones instead of wrapping.
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - synchronous active-high reset (to zero)
//   clr_i  - synchronous clear (to zero), same effect as reset
//   en_i   - count enable, one increment per high cycle
//   cnt_o  - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline event counters with snapshot readout
//
// Purpose: counts run cycles and per-channel pipeline events while in RUN,
//          halts after MAX_CYCLES run cycles (0 = never), and exposes a
//          snapshot (shadow) bank through a registered read port.
// Ports:
//   clk_i      - rising-edge clock
//   rst_i      - synchronous active-high reset
//   start_i    - level, IDLE -> RUN
//   clear_i    - pulse, zero live counters and return to IDLE
//   evt_i      - per-channel event strobes
//   snap_i     - pulse, copy live counters into shadow bank
//   rd_sel_i   - shadow select (0 = cycles, k = event k-1)
//   rd_data_o  - registered shadow readout
//   running_o  - high in RUN
//   halt_o     - high in HALTED
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 70,
  parameter int SEL_W      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               running_o,
  output logic               halt_o
);

  // Halt is decided on the edge where cycle_cnt goes from MAX_CYCLES-1 to
  // MAX_CYCLES; the compare is done 64 bits wide so a limit larger than the
  // counter can never alias onto a small count.
  localparam logic [63:0] LAST_CYC = (MAX_CYCLES > 0) ? 64'(MAX_CYCLES - 1) : 64'd0;

  logic [1:0]                     state_q;
  logic [1:0]                     state_d;
  logic                           run;
  logic                           last_cycle;
  logic [NUM_EVT:0][CNT_W-1:0]    live;
  logic [CNT_W-1:0]               shadow [NUM_EVT+1];
  logic [CNT_W-1:0]               rd_next;

  assign run        = (state_q == ST_RUN);
  assign last_cycle = (MAX_CYCLES != 0) && run &&
                      (64'(live[SEL_CYCLE]) == LAST_CYC);

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_i) state_d = ST_RUN;
        ST_RUN:    if (last_cycle) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign running_o = state_q[0];
  assign halt_o    = state_q[1];

  // The final RUN edge (into HALTED) still counts because enables key off
  // the registered state, not the next state.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .en_i  (run),
    .cnt_o (live[SEL_CYCLE])
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    sat_counter #(.W(CNT_W)) u_evt_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (run && evt_i[k]),
      .cnt_o (live[SEL_EVT_BASE+k])
    );
  end

  // Shadow takes the pre-increment live values; clear does not touch it, so
  // a same-cycle snap+clear keeps the values being cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= NUM_EVT; i++) shadow[i] <= '0;
    end else if (snap_i) begin
      for (int i = 0; i <= NUM_EVT; i++) shadow[i] <= live[i];
    end
  end

  // Selects beyond the last event fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_next = shadow[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_next;
    end
  end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - self-checking bench for pipe_perf_monitor
module tb_pipe_perf_monitor;

  logic       clk = 1'b0;
  logic [2:0] rst, start, clear, snap;
  logic [3:0] evt [3];
  logic [2:0] sel [3];

  logic [31:0] rd0, rd2;
  logic [3:0]  rd1;
  logic        run0, run1, run2, halt0, halt1, halt2;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int          phase;
    int          d;
    logic [2:0]  sel;
    logic [31:0] exp;
  } rvec_t;

  rvec_t       vt[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // u0: defaults (MAX_CYCLES=70), u1: 4-bit counters, u2: no cycle limit
  pipe_perf_monitor u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .clear_i(clear[0]),
    .evt_i(evt[0]), .snap_i(snap[0]), .rd_sel_i(sel[0]),
    .rd_data_o(rd0), .running_o(run0), .halt_o(halt0));

  pipe_perf_monitor #(.CNT_W(4)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .clear_i(clear[1]),
    .evt_i(evt[1]), .snap_i(snap[1]), .rd_sel_i(sel[1]),
    .rd_data_o(rd1), .running_o(run1), .halt_o(halt1));

  pipe_perf_monitor #(.MAX_CYCLES(0)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .clear_i(clear[2]),
    .evt_i(evt[2]), .snap_i(snap[2]), .rd_sel_i(sel[2]),
    .rd_data_o(rd2), .running_o(run2), .halt_o(halt2));

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return rd0;
      1:       return {28'd0, rd1};
      default: return rd2;
    endcase
  endfunction

  function automatic logic run_of(input int d);
    case (d)
      0:       return run0;
      1:       return run1;
      default: return run2;
    endcase
  endfunction

  function automatic logic halt_of(input int d);
    case (d)
      0:       return halt0;
      1:       return halt1;
      default: return halt2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reads(input int ph);
    foreach (vt[i]) begin
      if (vt[i].phase == ph) begin
        sel[vt[i].d] = vt[i].sel;
        exp_q.push_back(vt[i].exp);
        step();
        chk($sformatf("p%0d u%0d sel%0d", ph, vt[i].d, vt[i].sel),
            rd_of(vt[i].d), exp_q.pop_front());
      end
    end
    for (int d = 0; d < 3; d++) sel[d] = 3'd0;
  endtask

  task automatic pulse_snap(input int d);
    snap[d] = 1'b1;
    step();
    snap[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int halt_seen;

    // phase 1: 70-cycle run, evt0 for 12 cycles (sel 5 and 7 out of range)
    vt.push_back('{1, 0, 3'd0, 32'd70});
    vt.push_back('{1, 0, 3'd1, 32'd12});
    vt.push_back('{1, 0, 3'd2, 32'd0});
    vt.push_back('{1, 0, 3'd3, 32'd0});
    vt.push_back('{1, 0, 3'd4, 32'd0});
    vt.push_back('{1, 0, 3'd5, 32'd0});
    vt.push_back('{1, 0, 3'd7, 32'd0});
    // phase 2: after snap+clear at cycle 33 (evt1 seen 5 times)
    vt.push_back('{2, 0, 3'd0, 32'd33});
    vt.push_back('{2, 0, 3'd2, 32'd5});
    // phase 3: snap after clear -> live bank is zero
    vt.push_back('{3, 0, 3'd0, 32'd0});
    vt.push_back('{3, 0, 3'd1, 32'd0});
    vt.push_back('{3, 0, 3'd2, 32'd0});
    // phase 4: snap on first RUN edge after a mid-run reset
    for (int s = 0; s <= 4; s++) vt.push_back('{4, 0, 3'(s), 32'd0});
    // phase 5: second snap, 6 cycles and one hit per channel before it
    vt.push_back('{5, 0, 3'd0, 32'd6});
    for (int s = 1; s <= 4; s++) vt.push_back('{5, 0, 3'(s), 32'd1});
    // phase 6: 4-bit counters saturate
    vt.push_back('{6, 1, 3'd2, 32'd15});
    vt.push_back('{6, 1, 3'd0, 32'd15});
    vt.push_back('{6, 1, 3'd1, 32'd0});
    // phase 7: unlimited run of 200 cycles
    vt.push_back('{7, 2, 3'd0, 32'd200});
    vt.push_back('{7, 2, 3'd1, 32'd0});

    rst = 3'b111; start = '0; clear = '0; snap = '0;
    for (int d = 0; d < 3; d++) begin
      evt[d] = 4'h0;
      sel[d] = 3'd0;
    end
    step();
    rst = 3'b000;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset u%0d running", d), 32'(run_of(d)), 32'd0);
      chk($sformatf("reset u%0d halt", d), 32'(halt_of(d)), 32'd0);
      chk($sformatf("reset u%0d rd_data", d), rd_of(d), 32'd0);
    end

    // u0: run to the 70-cycle limit; start stays high throughout
    start[0] = 1'b1;
    step();
    chk("u0 running after start", 32'(run0), 32'd1);
    for (int i = 0; i < 70; i++) begin
      evt[0] = (i < 12) ? 4'h1 : 4'h0;
      step();
      if (i == 68) begin
        chk("u0 running before limit", 32'(run0), 32'd1);
        chk("u0 halt before limit", 32'(halt0), 32'd0);
      end
    end
    chk("u0 halt at limit", 32'(halt0), 32'd1);
    chk("u0 running at limit", 32'(run0), 32'd0);
    evt[0] = 4'hF;
    for (int i = 0; i < 3; i++) step();
    chk("u0 halt held with start high", 32'(halt0), 32'd1);
    evt[0] = 4'h0;
    pulse_snap(0);
    do_reads(1);

    // u0: clear out of HALTED, then snap+clear together at cycle 33
    start[0] = 1'b0;
    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    chk("u0 halt after clear", 32'(halt0), 32'd0);
    chk("u0 running after clear", 32'(run0), 32'd0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 33; i++) begin
      evt[0] = (i < 5) ? 4'h2 : 4'h0;
      step();
    end
    evt[0] = 4'hF;
    sel[0] = 3'd0;
    snap[0] = 1'b1;
    clear[0] = 1'b1;
    exp_q.push_back(32'd70);
    step();
    snap[0] = 1'b0;
    clear[0] = 1'b0;
    evt[0] = 4'h0;
    chk("u0 read during snap returns old", rd0, exp_q.pop_front());
    chk("u0 running after snap+clear", 32'(run0), 32'd0);
    chk("u0 halt after snap+clear", 32'(halt0), 32'd0);
    do_reads(2);
    pulse_snap(0);
    do_reads(3);

    // u0: reset on the 10th RUN edge with all events high
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    evt[0] = 4'hF;
    for (int i = 0; i < 9; i++) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    evt[0] = 4'h0;
    chk("u0 running after mid-run reset", 32'(run0), 32'd0);
    chk("u0 halt after mid-run reset", 32'(halt0), 32'd0);
    chk("u0 rd_data after mid-run reset", rd0, 32'd0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    evt[0] = 4'hF;
    pulse_snap(0);
    evt[0] = 4'h0;
    do_reads(4);
    pulse_snap(0);
    do_reads(5);

    // u1: 4-bit counters, evt1 high for 20 RUN cycles
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    evt[1] = 4'h2;
    for (int i = 0; i < 20; i++) step();
    evt[1] = 4'h0;
    chk("u1 halt with saturated cycle count", 32'(halt1), 32'd0);
    pulse_snap(1);
    do_reads(6);

    // u2: no limit, 200 RUN cycles
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    halt_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (halt2) halt_seen++;
    end
    chk("u2 halt never asserts", 32'(halt_seen), 32'd0);
    chk("u2 still running", 32'(run2), 32'd1);
    pulse_snap(2);
    do_reads(7);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
